traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
- Observer at the far end of the controller's lamp interface. It consumes the two 3-bit one-hot lamp buses A and B each oclk tick.
- Decodes them back to a traffic phase and measures how long each phase lasts.
- Checks phase ordering, dwell bounds and lamp-code legality, and reports sticky error flags plus a saturating error counter for display/debug.

Parameters:
GREEN_MIN, 2, minimum legal dwell (ticks) of a green phase (S0, S2)
GREEN_MAX, 4, maximum legal dwell (ticks) of a green phase
YELLOW_MIN, 1, minimum legal dwell of a yellow phase (S1, S3)
YELLOW_MAX, 2, maximum legal dwell of a yellow phase
CNT_W, 8, width of dwell and error counters

Ports:
oclk  in  1  divided system clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
A  in  3  lamp bus road A: 001 red, 010 green, 100 yellow
B  in  3  lamp bus road B, same coding
clr  in  1  synchronous clear of sticky flags and error count; leaves FAULT
phase  out  2  last decoded legal phase: 0=S0(A grn/B red), 1=S1(A yel/B red), 2=S2(A red/B grn), 3=S3(A red/B yel)
phase_valid  out  1  high in TRACK state
dwell  out  CNT_W  ticks the current phase has been sampled; 1 on first tick, saturates at all-ones
last_dwell  out  CNT_W  final dwell of the previous phase, captured at each phase change
err_seq  out  1  sticky: a non-successor phase followed the current phase
err_short  out  1  sticky: a phase ended with dwell below its MIN
err_long  out  1  sticky: a phase exceeded its MAX
err_illegal  out  1  sticky: A/B pair was not one of the four legal codes
err_count  out  CNT_W  number of cycles with at least one new error event; saturating

Behaviour:
- Reset (rst=0 at edge): state=SYNC, phase=0, phase_valid=0, dwell=0, last_dwell=0, all err_* =0, err_count=0, first_seg=1. Reset has priority over clr and over everything else, including mid-phase.
- Decode is combinational: the four legal {A,B} pairs map to S0..S3. Any other pair, including non-one-hot values, is ILLEGAL.
- Outputs are registered and reflect the A/B sample taken at the same edge. Latency is 1 oclk from lamp change to output.
- States:
  - SYNC: wait for a legal code. On a legal code: phase<=code, dwell<=1, first_seg<=1, go to TRACK. ILLEGAL stays in SYNC, raises err_illegal and counts one event.
  - TRACK:
    - Same code: dwell<=dwell+1 (saturating). If the new dwell equals MAX(phase)+1, pulse the long event once (err_long<=1). It does not re-fire for the same phase occurrence.
    - Different legal code q: last_dwell<=dwell.
      - If q != (phase+1) mod 4: seq event.
      - If first_seg=0 and dwell < MIN(phase): short event. The first segment after SYNC is partial and is never short-checked.
      - Then phase<=q, dwell<=1, first_seg<=0.
    - ILLEGAL: illegal event, phase_valid<=0, go to FAULT. phase and dwell hold.
  - FAULT: dwell, phase and last_dwell frozen; further ILLEGAL samples do not count. clr=1 moves to SYNC.
- MIN/MAX selection: phase S0/S2 use GREEN_*, S1/S3 use YELLOW_*.
- err_count increments by exactly 1 in any cycle with one or more new events (e.g. seq+short together = +1). It holds at all-ones.
- clr=1 (rst=1):
  - Clears all err_* flags and err_count that cycle.
  - In FAULT, goes to SYNC.
  - In TRACK, tracking continues. Events detected in the same cycle as clr are discarded; clr wins.
- dwell saturation: at all-ones, dwell holds. The long event was already raised earlier.

Decomposition:
- Shared package traffic_pkg holds:
  - lamp constants LAMP_RED=3'b001, LAMP_GRN=3'b010, LAMP_YEL=3'b100
  - phase encoding S0..S3
  - monitor state encoding SYNC/TRACK/FAULT
- The controller and the monitor both import it.
- One sub-module, lamp_decode: combinational {A,B} -> {legal, phase[1:0]}. It is reusable by any other lamp consumer.

Test Plan:
- Legal cycle: rst low 2 ticks, then S0x3, S1x1, S2x3, S3x1, repeated twice -> phase_valid=1 after first sample; last_dwell 3,1,3,1; all err_*=0; err_count=0.
- Short: after a legal S3, drive S0x1 then S1 -> at the S1 edge err_short=1, last_dwell=1, err_count=1; phase=1.
- Long + skip: S0x5 -> err_long rises on the 5th S0 tick, err_count=1; then S2 directly -> err_seq=1, err_count=2; no short flagged.
- Illegal: in TRACK drive A=010,B=010 -> err_illegal=1, phase_valid=0, dwell frozen; hold 3 ticks -> err_count=1. clr pulse -> flags 0, count 0, SYNC; next legal S2 -> phase=2, dwell=1, TRACK.
- Reset mid-operation: during S2 with dwell=2 and err_seq=1, assert rst 1 tick -> all outputs at reset values next edge; first following segment S1x1 then S2 gives no short error (first_seg).

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp-interface definitions for the traffic light controller and its monitor.
// Lamp codes, phase encoding and monitor state encoding.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED = 3'b001;
    localparam logic [2:0] LAMP_GRN = 3'b010;
    localparam logic [2:0] LAMP_YEL = 3'b100;

    typedef enum logic [1:0] {
        S0 = 2'd0,  // A green,  B red
        S1 = 2'd1,  // A yellow, B red
        S2 = 2'd2,  // A red,    B green
        S3 = 2'd3   // A red,    B yellow
    } phase_e;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } mon_state_e;

    function automatic phase_e next_phase(input phase_e p);
        return phase_e'(p + 2'd1);
    endfunction

    function automatic logic is_green_phase(input phase_e p);
        return ~p[0];
    endfunction

endpackage

// File: rtl/lamp_decode.sv
// Combinational decode of the A/B lamp buses into a traffic phase.
// Any pair other than the four legal codes (including non-one-hot values) is illegal.
module lamp_decode
    import traffic_pkg::*;
(
    input  logic [2:0] a_i,
    input  logic [2:0] b_i,
    output logic       legal_o,
    output phase_e     phase_o
);

    always_comb begin
        legal_o = 1'b1;
        phase_o = S0;
        unique case ({a_i, b_i})
            {LAMP_GRN, LAMP_RED}: phase_o = S0;
            {LAMP_YEL, LAMP_RED}: phase_o = S1;
            {LAMP_RED, LAMP_GRN}: phase_o = S2;
            {LAMP_RED, LAMP_YEL}: phase_o = S3;
            default:              legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Observes the lamp buses, tracks phase sequence and dwell, and raises sticky
// error flags plus a saturating error-event counter.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN  = 2,
    parameter int GREEN_MAX  = 4,
    parameter int YELLOW_MIN = 1,
    parameter int YELLOW_MAX = 2,
    parameter int CNT_W      = 8
) (
    input  logic             oclk,
    input  logic             rst,
    input  logic [2:0]       A,
    input  logic [2:0]       B,
    input  logic             clr,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [CNT_W-1:0] dwell,
    output logic [CNT_W-1:0] last_dwell,
    output logic             err_seq,
    output logic             err_short,
    output logic             err_long,
    output logic             err_illegal,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] dwell_min(input phase_e p);
        return is_green_phase(p) ? CNT_W'(GREEN_MIN) : CNT_W'(YELLOW_MIN);
    endfunction

    function automatic logic [CNT_W-1:0] dwell_over(input phase_e p);
        return is_green_phase(p) ? CNT_W'(GREEN_MAX + 1) : CNT_W'(YELLOW_MAX + 1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    logic       dec_legal;
    phase_e     dec_phase;

    lamp_decode u_lamp_decode (
        .a_i     (A),
        .b_i     (B),
        .legal_o (dec_legal),
        .phase_o (dec_phase)
    );

    mon_state_e       state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] last_dwell_q, last_dwell_d;
    logic             first_seg_q, first_seg_d;
    logic             err_seq_q, err_seq_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic             err_ill_q, err_ill_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             ev_seq, ev_short, ev_long, ev_ill;
    logic [CNT_W-1:0] dwell_inc;

    assign dwell_inc = sat_inc(dwell_q);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        dwell_d      = dwell_q;
        last_dwell_d = last_dwell_q;
        first_seg_d  = first_seg_q;
        ev_seq       = 1'b0;
        ev_short     = 1'b0;
        ev_long      = 1'b0;
        ev_ill       = 1'b0;

        unique case (state_q)
            SYNC: begin
                if (dec_legal) begin
                    phase_d     = dec_phase;
                    dwell_d     = ONE;
                    first_seg_d = 1'b1;
                    state_d     = TRACK;
                end else begin
                    ev_ill = 1'b1;
                end
            end
            TRACK: begin
                if (!dec_legal) begin
                    ev_ill  = 1'b1;
                    state_d = FAULT;
                end else if (dec_phase == phase_q) begin
                    dwell_d = dwell_inc;
                    // Fires only on the crossing tick, so a saturated dwell never re-fires.
                    ev_long = (dwell_inc != dwell_q) && (dwell_inc == dwell_over(phase_q));
                end else begin
                    last_dwell_d = dwell_q;
                    ev_seq       = (dec_phase != next_phase(phase_q));
                    // The segment seen on entry from SYNC is partial, so its length is meaningless.
                    ev_short     = !first_seg_q && (dwell_q < dwell_min(phase_q));
                    phase_d      = dec_phase;
                    dwell_d      = ONE;
                    first_seg_d  = 1'b0;
                end
            end
            FAULT: begin
                if (clr) begin
                    state_d = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        err_seq_d   = err_seq_q   | ev_seq;
        err_short_d = err_short_q | ev_short;
        err_long_d  = err_long_q  | ev_long;
        err_ill_d   = err_ill_q   | ev_ill;
        err_count_d = (ev_seq || ev_short || ev_long || ev_ill) ? sat_inc(err_count_q) : err_count_q;
        if (clr) begin
            err_seq_d   = 1'b0;
            err_short_d = 1'b0;
            err_long_d  = 1'b0;
            err_ill_d   = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge oclk) begin
        if (!rst) begin
            state_q      <= SYNC;
            phase_q      <= S0;
            dwell_q      <= '0;
            last_dwell_q <= '0;
            first_seg_q  <= 1'b1;
            err_seq_q    <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            err_ill_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            dwell_q      <= dwell_d;
            last_dwell_q <= last_dwell_d;
            first_seg_q  <= first_seg_d;
            err_seq_q    <= err_seq_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            err_ill_q    <= err_ill_d;
            err_count_q  <= err_count_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = (state_q == TRACK);
    assign dwell       = dwell_q;
    assign last_dwell  = last_dwell_q;
    assign err_seq     = err_seq_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign err_illegal = err_ill_q;
    assign err_count   = err_count_q;

endmodule
